// File: rtl/irq_ctrl_if.sv
// Word-addressed register bus shared with the other memory-mapped devices.
// The CPU side drives Addr/WE/Din; the device returns Dout combinationally.
interface irq_ctrl_if;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output Addr, output WE, output Din, input Dout);
  modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending latch, mask, fixed priority (index 0 highest), single CPU request with EOI.
// Define IRQ_SYNC_EN to pass irq_in through a 2-flop synchroniser before sampling.
module irq_ctrl #(
  parameter int NUM_IRQ = 6
) (
  input  logic               clk,
  input  logic               reset,
  irq_ctrl_if.slave          bus,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               int_ack,
  output logic               int_req,
  output logic [NUM_IRQ-1:0] hwint
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERV = 2'd2} state_t;

  state_t             state_r, state_nxt_s;
  logic [4:0]         idx_r, idx_nxt_s;
  logic               int_req_r;
  logic [NUM_IRQ-1:0] pend_r, pend_nxt_s;
  logic [NUM_IRQ-1:0] mask_r, mode_r;
  logic [NUM_IRQ-1:0] samp_s, samp_d_r, rise_s, active_s;
  logic               we_mask_s, we_pend_s, we_mode_s, eoi_s;
  logic               unused_s;

  function automatic logic [4:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      r = v[i] ? 5'(i) : r;
    end
    return r;
  endfunction

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_r, sync2_r;

  // Two-stage synchroniser for asynchronous device lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= irq_in;
      sync2_r <= sync1_r;
    end
  end
  assign samp_s = sync2_r;
`else
  assign samp_s = irq_in;
`endif

  assign we_mask_s = bus.WE && (bus.Addr[3:2] == 2'd0);
  assign we_pend_s = bus.WE && (bus.Addr[3:2] == 2'd1);
  assign we_mode_s = bus.WE && (bus.Addr[3:2] == 2'd2);
  assign eoi_s     = bus.WE && (bus.Addr[3:2] == 2'd3);
  assign rise_s    = samp_s & ~samp_d_r;
  assign active_s  = pend_r & mask_r;
  assign hwint     = active_s;
  assign int_req   = int_req_r;
  assign unused_s  = ^{bus.Addr[31:4], bus.Din[31:NUM_IRQ]};

  // Pending update: level bits follow the line; edge bits latch rises, set beats clear.
  always_comb begin
    pend_nxt_s = pend_r;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (mode_r[i]) begin
        pend_nxt_s[i] = rise_s[i] |
                        (pend_r[i] & ~((we_pend_s & bus.Din[i]) |
                                       (eoi_s && (state_r == SERV) && (idx_r == 5'(i)))));
      end else begin
        pend_nxt_s[i] = samp_s[i];
      end
    end
  end

  // Request FSM next state; a request withdrawn in REQ takes priority over int_ack.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (|active_s) state_nxt_s = REQ;
        else           state_nxt_s = IDLE;
      end
      REQ: begin
        if (~|active_s) begin
          state_nxt_s = IDLE;
        end else if (int_ack) begin
          state_nxt_s = SERV;
          idx_nxt_s   = lowest_idx(active_s);
        end else begin
          state_nxt_s = REQ;
        end
      end
      SERV: begin
        if (eoi_s) begin
          state_nxt_s = IDLE;
          idx_nxt_s   = 5'd0;
        end else begin
          state_nxt_s = SERV;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = 5'd0;
      end
    endcase
  end

  // State, configuration and pending registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      idx_r     <= 5'd0;
      int_req_r <= 1'b0;
      pend_r    <= '0;
      mask_r    <= '0;
      mode_r    <= '0;
      samp_d_r  <= '0;
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      int_req_r <= (state_nxt_s == REQ);
      pend_r    <= pend_nxt_s;
      samp_d_r  <= samp_s;
      if (we_mask_s) mask_r <= bus.Din[NUM_IRQ-1:0];
      else           mask_r <= mask_r;
      if (we_mode_s) mode_r <= bus.Din[NUM_IRQ-1:0];
      else           mode_r <= mode_r;
    end
  end

  // Register read mux; bits above NUM_IRQ read as zero.
  always_comb begin
    bus.Dout = 32'd0;
    case (bus.Addr[3:2])
      2'd0:    bus.Dout = {{(32-NUM_IRQ){1'b0}}, mask_r};
      2'd1:    bus.Dout = {{(32-NUM_IRQ){1'b0}}, pend_r};
      2'd2:    bus.Dout = {{(32-NUM_IRQ){1'b0}}, mode_r};
      2'd3:    bus.Dout = {(state_r == SERV), 26'd0, idx_r};
      default: bus.Dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl (default build, irq_in sampled without synchroniser).
module tb_irq_ctrl;
  logic       clk;
  logic       reset;
  logic [5:0] irq_in;
  logic       int_ack;
  logic       int_req;
  logic [5:0] hwint;
  int         checks;
  int         errors;

  irq_ctrl_if bus ();

  irq_ctrl #(.NUM_IRQ(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .irq_in  (irq_in),
    .int_ack (int_ack),
    .int_req (int_req),
    .hwint   (hwint)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = {28'd0, a};
    bus.Din  = d;
    bus.WE   = 1'b1;
    tick();
    bus.WE   = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.Addr = {28'd0, a};
    #1;
    check(tag, bus.Dout, exp);
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    irq_in   = 6'd0;
    int_ack  = 1'b0;
    bus.Addr = 30'd0;
    bus.WE   = 1'b0;
    bus.Din  = 32'd0;
    tick();
    tick();
    check("rst_int_req", {31'd0, int_req}, 32'd0);
    rd_check("rst_mask", 2'd0, 32'd0);
    rd_check("rst_pend", 2'd1, 32'd0);
    rd_check("rst_mode", 2'd2, 32'd0);
    rd_check("rst_vec", 2'd3, 32'd0);
    reset = 1'b1;
    tick();

    // int_ack and EOI while idle are ignored
    ack_pulse();
    wr(2'd3, 32'd0);
    check("idle_ack_ign", {31'd0, int_req}, 32'd0);
    rd_check("idle_eoi_vec", 2'd3, 32'd0);

    // Basic level request on line 0: PEND after edge k, int_req after k+1
    wr(2'd0, 32'h01);
    wr(2'd2, 32'h00);
    irq_in = 6'h01;
    tick();
    rd_check("lat_pend", 2'd1, 32'h01);
    check("lat_req_early", {31'd0, int_req}, 32'd0);
    tick();
    check("lat_req", {31'd0, int_req}, 32'd1);
    check("lat_hwint", {26'd0, hwint}, 32'h01);
    ack_pulse();
    rd_check("l0_vec", 2'd3, 32'h80000000);
    irq_in = 6'h00;
    wr(2'd3, 32'd0);
    rd_check("l0_eoi_vec", 2'd3, 32'd0);
    tick();
    check("l0_idle", {31'd0, int_req}, 32'd0);

    // Priority: lines 2 and 3, lowest index served first; upper MASK bits ignored
    wr(2'd0, 32'hFFFFFFFF);
    rd_check("mask_width", 2'd0, 32'h3F);
    irq_in = 6'h0C;
    tick();
    tick();
    check("pri_req", {31'd0, int_req}, 32'd1);
    ack_pulse();
    rd_check("pri_vec2", 2'd3, 32'h80000002);
    check("pri_req_serv", {31'd0, int_req}, 32'd0);
    irq_in = 6'h08;
    tick();
    check("pri_nonest", {31'd0, int_req}, 32'd0);
    wr(2'd3, 32'd0);
    rd_check("pri_eoi_vec", 2'd3, 32'd0);
    tick();
    check("pri_req_again", {31'd0, int_req}, 32'd1);
    ack_pulse();
    rd_check("pri_vec3", 2'd3, 32'h80000003);
    irq_in = 6'h00;
    wr(2'd3, 32'd0);
    tick();
    check("pri_done", {31'd0, int_req}, 32'd0);

    // Edge mode on line 1, masked: pulse latches, W1C clears
    wr(2'd2, 32'h02);
    wr(2'd0, 32'h00);
    irq_in = 6'h02;
    tick();
    irq_in = 6'h00;
    tick();
    tick();
    rd_check("edge_held", 2'd1, 32'h02);
    check("edge_masked_req", {31'd0, int_req}, 32'd0);
    wr(2'd1, 32'h02);
    rd_check("edge_w1c", 2'd1, 32'h00);

    // Rising edge coincident with W1C: set wins
    irq_in = 6'h02;
    wr(2'd1, 32'h02);
    rd_check("edge_set_wins", 2'd1, 32'h02);
    irq_in = 6'h00;
    wr(2'd1, 32'h02);
    rd_check("edge_clr2", 2'd1, 32'h00);

    // Level line 4 drops while in REQ: request withdrawn, late int_ack ignored
    wr(2'd2, 32'h00);
    wr(2'd0, 32'h10);
    irq_in = 6'h10;
    tick();
    tick();
    check("drop_req", {31'd0, int_req}, 32'd1);
    irq_in = 6'h00;
    tick();
    ack_pulse();
    check("drop_req_off", {31'd0, int_req}, 32'd0);
    rd_check("drop_vec", 2'd3, 32'd0);
    check("drop_hwint", {26'd0, hwint}, 32'd0);

    // Asynchronous reset while servicing
    wr(2'd0, 32'h01);
    irq_in = 6'h01;
    tick();
    tick();
    ack_pulse();
    rd_check("serv_vec", 2'd3, 32'h80000000);
    #1;
    reset = 1'b0;
    #1;
    check("arst_int_req", {31'd0, int_req}, 32'd0);
    rd_check("arst_mask", 2'd0, 32'd0);
    rd_check("arst_pend", 2'd1, 32'd0);
    rd_check("arst_mode", 2'd2, 32'd0);
    rd_check("arst_vec", 2'd3, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
